// File: rtl/alu_control_seq.sv
// alu_control_seq: registered, handshaked ALU-control decoder with an iterative multi-beat mode.
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   flush             synchronous kill of the pending/in-flight op (highest priority)
//   in_valid/in_ready input handshake carrying ops/func
//   ops, func         main-control ALU class and instruction function field
//   out_valid/out_ready output handshake carrying aluop/step/last
//   aluop             ALU operation
//   step              micro-op index within an iterative sequence, 0 for single-beat ops
//   last              final beat of the current op
module alu_control_seq #(
    parameter int unsigned OPS_W      = 3,
    parameter int unsigned FUNC_W     = 4,
    parameter int unsigned ALUOP_W    = 3,
    parameter int unsigned ADD_CODE   = 0,
    parameter int unsigned SUB_CODE   = 2,
    parameter int unsigned ITER_FUNC  = 15,
    parameter int unsigned ITER_OP    = 1,
    parameter int unsigned ITER_STEPS = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPS_W-1:0]   ops,
    input  logic [FUNC_W-1:0]  func,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] aluop,
    output logic [CNT_W-1:0]   step,
    output logic               last
);
    typedef enum logic [1:0] {IDLE, BEAT, ITER} state_t;

    state_t             state_q, state_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic [ALUOP_W-1:0] func_r, dec;
    logic               iter_sel, accept, iter_more;

    // func is zero-extended or truncated (LSBs kept) to the aluop width
    generate
        if (FUNC_W >= ALUOP_W) begin : g_trunc
            assign func_r = func[ALUOP_W-1:0];
        end else begin : g_ext
            assign func_r = {{(ALUOP_W-FUNC_W){1'b0}}, func};
        end
        if (OPS_W > 3) begin : g_ops_hi
            logic unused_ops_hi;
            assign unused_ops_hi = ^ops[OPS_W-1:3];
        end
    endgenerate

    assign dec       = ops[2] ? func_r : (ops[1] & ops[0]) ? ALUOP_W'(SUB_CODE) : ALUOP_W'(ADD_CODE);
    assign iter_sel  = ops[2] && (func == FUNC_W'(ITER_FUNC));
    assign out_valid = state_q != IDLE;
    assign last      = (state_q == BEAT) || (state_q == ITER && step_q == CNT_W'(ITER_STEPS - 1));
    assign in_ready  = !out_valid || (out_ready && last);
    // flush drops whatever is presented in the same cycle
    assign accept    = in_valid && in_ready && !flush;
    assign iter_more = state_q == ITER && !last;
    assign aluop     = aluop_q;
    assign step      = step_q;

    always_comb begin
        state_d = state_q;
        aluop_d = aluop_q;
        step_d  = step_q;
        if (flush) begin
            state_d = IDLE;
            step_d  = '0;
        end else if (accept) begin
            state_d = iter_sel ? ITER : BEAT;
            aluop_d = iter_sel ? ALUOP_W'(ITER_OP) : dec;
            step_d  = '0;
        end else if (out_valid && out_ready) begin
            state_d = iter_more ? ITER : IDLE;
            step_d  = iter_more ? step_q + CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            aluop_q <= ALUOP_W'(ADD_CODE);
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            aluop_q <= aluop_d;
            step_q  <= step_d;
        end
    end
endmodule
